om_interval_reporter: RTL and testbench

OM_INTERVAL_REPORTER -- requirements
Module: om_interval_reporter

---
 rtl/om_interval_reporter.sv | 210 +++++++++++++++++++++
 tb/tb_om_interval_reporter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/om_interval_reporter.sv
// -----------------------------------------------------------------------------
// om_interval_reporter
//
// Drains the overflow-interval buffer to a valid/ready consumer, oldest entry
// first. A start request snapshots the buffer's write cursor and entry count.
// The reporter then walks the buffer one entry at a time:
//   - LOAD presents the index on the read port and registers the returned entry.
//   - SEND holds that beat until the consumer accepts it.
// As a result, at most one beat is produced every two cycles.
//
// Optional feature (compile-time macro OM_REPORT_SKIP_BIG_EN):
//   When defined, entries flagged "big" are dropped in LOAD without producing
//   a beat. They still count against the snapshotted entry count.
//
// Parameters:
//   SIZE   number of buffer entries (power of two)
//   IDX_W  log2(SIZE)
//
// Ports:
//   clk_i                 clock, rising edge
//   rst_i                 synchronous active-high reset (highest priority)
//   start_i               request a dump (honoured only when idle)
//   abort_i               cancel a dump in progress (beats_o is kept)
//   head_i, num_i         buffer write cursor and valid entry count
//   rd_idx_o              index driven to the buffer read port
//   ent_first_i,
//   ent_last_i,
//   ent_big_i             entry at rd_idx_o (same cycle)
//   out_valid_o,
//   out_ready_i           handshake to the consumer
//   out_first_o,
//   out_last_o,
//   out_big_o,
//   out_idx_o             payload of the current beat
//   busy_o                high whenever not idle
//   done_o                one-cycle pulse on completion
//   beats_o               beats accepted in the current/last dump
// -----------------------------------------------------------------------------
module om_interval_reporter #(
    parameter int SIZE  = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [IDX_W-1:0] head_i,
    input  logic [IDX_W:0]   num_i,
    output logic [IDX_W-1:0] rd_idx_o,
    input  logic [31:0]      ent_first_i,
    input  logic [31:0]      ent_last_i,
    input  logic             ent_big_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_first_o,
    output logic [31:0]      out_last_o,
    output logic             out_big_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W:0]   beats_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W:0]   CNT_ZERO = {(IDX_W+1){1'b0}};
    localparam logic [IDX_W:0]   CNT_ONE  = {{IDX_W{1'b0}}, 1'b1};

    state_t           state_r, state_nx_s;
    logic [IDX_W-1:0] idx_r, idx_nx_s, idx_inc_s;
    logic [IDX_W:0]   rem_r, rem_nx_s;
    logic [IDX_W:0]   beats_r, beats_nx_s;
    logic             load_s;
    logic             out_valid_r, done_r, busy_r, out_big_r;
    logic [31:0]      out_first_r, out_last_r;
    logic [IDX_W-1:0] out_idx_r;

    // Next buffer index, wrapping from the last slot back to zero.
    always_comb begin
        if (idx_r == IDX_LAST) begin
            idx_inc_s = {IDX_W{1'b0}};
        end else begin
            idx_inc_s = idx_r + IDX_ONE;
        end
    end

    // Next-state, cursor/count bookkeeping and payload-load strobe.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        rem_nx_s   = rem_r;
        beats_nx_s = beats_r;
        load_s     = 1'b0;
        if (abort_i) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        beats_nx_s = CNT_ZERO;
                        if (num_i == CNT_ZERO) begin
                            state_nx_s = DONE;
                        end else begin
                            // Oldest entry sits num slots behind the cursor; the
                            // power-of-two size makes truncation the modulo.
                            idx_nx_s   = head_i - num_i[IDX_W-1:0];
                            rem_nx_s   = num_i;
                            state_nx_s = LOAD;
                        end
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                LOAD: begin
`ifdef OM_REPORT_SKIP_BIG_EN
                    if (ent_big_i) begin
                        rem_nx_s = rem_r - CNT_ONE;
                        if (rem_r == CNT_ONE) begin
                            state_nx_s = DONE;
                        end else begin
                            idx_nx_s   = idx_inc_s;
                            state_nx_s = LOAD;
                        end
                    end else begin
                        load_s     = 1'b1;
                        state_nx_s = SEND;
                    end
`else
                    load_s     = 1'b1;
                    state_nx_s = SEND;
`endif
                end
                SEND: begin
                    if (out_ready_i) begin
                        beats_nx_s = beats_r + CNT_ONE;
                        if (rem_r == CNT_ONE) begin
                            state_nx_s = DONE;
                        end else begin
                            idx_nx_s   = idx_inc_s;
                            rem_nx_s   = rem_r - CNT_ONE;
                            state_nx_s = LOAD;
                        end
                    end else begin
                        state_nx_s = SEND;
                    end
                end
                DONE: begin
                    state_nx_s = IDLE;
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // State, bookkeeping and output registers; status flags follow the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            idx_r       <= {IDX_W{1'b0}};
            rem_r       <= CNT_ZERO;
            beats_r     <= CNT_ZERO;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            out_first_r <= 32'h0000_0000;
            out_last_r  <= 32'h0000_0000;
            out_big_r   <= 1'b0;
            out_idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            idx_r       <= idx_nx_s;
            rem_r       <= rem_nx_s;
            beats_r     <= beats_nx_s;
            out_valid_r <= (state_nx_s == SEND);
            done_r      <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s != IDLE);
            if (load_s) begin
                out_first_r <= ent_first_i;
                out_last_r  <= ent_last_i;
                out_big_r   <= ent_big_i;
                out_idx_r   <= idx_r;
            end else begin
                out_first_r <= out_first_r;
                out_last_r  <= out_last_r;
                out_big_r   <= out_big_r;
                out_idx_r   <= out_idx_r;
            end
        end
    end

    assign rd_idx_o    = idx_r;
    assign out_valid_o = out_valid_r;
    assign done_o      = done_r;
    assign busy_o      = busy_r;
    assign beats_o     = beats_r;
    assign out_first_o = out_first_r;
    assign out_last_o  = out_last_r;
    assign out_big_o   = out_big_r;
    assign out_idx_o   = out_idx_r;

endmodule

// File: tb/tb_om_interval_reporter.sv
// -----------------------------------------------------------------------------
// tb_om_interval_reporter
//
// Directed testbench for om_interval_reporter. A behavioural buffer answers
// the read port. Each scenario task drives a dump and compares what the
// consumer side observed against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_om_interval_reporter;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, abort_i, out_ready_i;
    logic [4:0]  head_i, rd_idx_o, out_idx_o;
    logic [5:0]  num_i, beats_o;
    logic [31:0] ent_first_i, ent_last_i, out_first_o, out_last_o;
    logic        ent_big_i, out_valid_o, out_big_o, busy_o, done_o;

    logic [31:0] mem_first [32];
    logic [31:0] mem_last  [32];
    logic        mem_big   [32];

    int n_cmp = 0;
    int n_err = 0;

    // Observations collected by run_dump.
    logic [4:0]  obs_idx[$];
    logic [31:0] obs_first[$];
    logic [31:0] obs_last[$];
    logic        obs_big[$];
    int          obs_cyc[$];
    int done_cnt, done_cyc, last_acc, stable_err, valid_seen, timeout;
    logic exit_valid;

    om_interval_reporter #(.SIZE(32), .IDX_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .head_i(head_i), .num_i(num_i), .rd_idx_o(rd_idx_o),
        .ent_first_i(ent_first_i), .ent_last_i(ent_last_i), .ent_big_i(ent_big_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_first_o(out_first_o), .out_last_o(out_last_o), .out_big_o(out_big_o),
        .out_idx_o(out_idx_o), .busy_o(busy_o), .done_o(done_o), .beats_o(beats_o)
    );

    always #5 clk_i = ~clk_i;

    assign ent_first_i = mem_first[rd_idx_o];
    assign ent_last_i  = mem_last[rd_idx_o];
    assign ent_big_i   = mem_big[rd_idx_o];

    // Start a dump and act as the consumer until the reporter goes idle.
    // After the start cycle, head/num are disturbed to prove they are not re-sampled.
    task automatic run_dump(input logic [4:0] head, input logic [5:0] num,
                            input int stall_beat, input int stall_cycles,
                            input int abort_beat, input bit hold_start);
        int cyc, stall_left, nb;
        logic prev_valid, prev_hold, pb;
        logic [31:0] pf, pl;
        logic [4:0] pi;
        obs_idx.delete(); obs_first.delete(); obs_last.delete();
        obs_big.delete(); obs_cyc.delete();
        done_cnt = 0; done_cyc = -1; last_acc = -1; stable_err = 0;
        valid_seen = 0; timeout = 0; exit_valid = 1'b0;
        stall_left = stall_cycles; nb = 0;
        prev_valid = 1'b0; prev_hold = 1'b0; pf = '0; pl = '0; pb = 1'b0; pi = '0;
        @(negedge clk_i);
        head_i = head; num_i = num; start_i = 1'b1; abort_i = 1'b0; out_ready_i = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge clk_i);
            cyc++;
            head_i = head + 5'd5;
            num_i  = 6'd7;
            if (!hold_start) start_i = 1'b0;
            abort_i = 1'b0;
            if (prev_valid && prev_hold) begin
                if (!out_valid_o || out_first_o !== pf || out_last_o !== pl ||
                    out_big_o !== pb || out_idx_o !== pi) stable_err++;
            end
            prev_hold = 1'b0;
            if (out_valid_o) begin
                valid_seen++;
                if (nb == abort_beat) begin
                    abort_i = 1'b1; out_ready_i = 1'b0;
                end else if (nb == stall_beat && stall_left > 0) begin
                    out_ready_i = 1'b0; stall_left--; prev_hold = 1'b1;
                end else begin
                    out_ready_i = 1'b1;
                end
                if (out_ready_i) begin
                    obs_idx.push_back(out_idx_o); obs_first.push_back(out_first_o);
                    obs_last.push_back(out_last_o); obs_big.push_back(out_big_o);
                    obs_cyc.push_back(cyc);
                    nb++; last_acc = cyc;
                end
            end else begin
                out_ready_i = 1'b1;
            end
            prev_valid = out_valid_o;
            pf = out_first_o; pl = out_last_o; pb = out_big_o; pi = out_idx_o;
            if (done_o) begin
                done_cnt++; done_cyc = cyc; start_i = 1'b0;
            end
            if (!busy_o) begin
                exit_valid = out_valid_o;
                break;
            end
            if (cyc >= 300) begin
                timeout = 1;
                break;
            end
        end
        start_i = 1'b0; abort_i = 1'b0; out_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b1; abort_i = 1'b0; out_ready_i = 1'b1;
        head_i = 5'd3; num_i = 6'd3;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if ({out_valid_o, done_o, busy_o, out_big_o} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got %b want 0000", {out_valid_o, done_o, busy_o, out_big_o});
        end
        n_cmp++;
        if ({beats_o, rd_idx_o, out_idx_o, out_first_o, out_last_o} !== 80'd0) begin
            n_err++;
            $display("FAIL reset_values beats=%0d rd=%0d idx=%0d first=%h last=%h want all 0",
                     beats_o, rd_idx_o, out_idx_o, out_first_o, out_last_o);
        end
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        run_dump(5'd3, 6'd3, -1, 0, -1, 1'b1);
        n_cmp++;
        if (timeout != 0 || obs_idx.size() != 3) begin
            n_err++; $display("FAIL basic_count got %0d beats (timeout=%0d) want 3", obs_idx.size(), timeout);
        end
        for (int k = 0; k < 3 && k < obs_idx.size(); k++) begin
            n_cmp++;
            if (obs_idx[k] !== 5'(k) || obs_first[k] !== 32'h100 * (k + 1) ||
                obs_last[k] !== 32'h100 * (k + 1) + 32'hFF || obs_cyc[k] != 2 + 2 * k) begin
                n_err++;
                $display("FAIL basic_beat%0d got idx=%0d first=%h last=%h cyc=%0d want idx=%0d first=%h last=%h cyc=%0d",
                         k, obs_idx[k], obs_first[k], obs_last[k], obs_cyc[k],
                         k, 32'h100 * (k + 1), 32'h100 * (k + 1) + 32'hFF, 2 + 2 * k);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != last_acc + 1) begin
            n_err++; $display("FAIL basic_done got count=%0d at %0d want 1 at %0d", done_cnt, done_cyc, last_acc + 1);
        end
        n_cmp++;
        if (beats_o !== 6'd3) begin
            n_err++; $display("FAIL basic_beats got %0d want 3", beats_o);
        end
    endtask

    task automatic test_wrap();
        run_dump(5'd2, 6'd32, -1, 0, -1, 1'b0);
        n_cmp++;
        if (timeout != 0 || obs_idx.size() != 32 || done_cnt != 1 || beats_o !== 6'd32) begin
            n_err++;
            $display("FAIL wrap_totals got beats=%0d done=%0d beats_o=%0d timeout=%0d want 32/1/32/0",
                     obs_idx.size(), done_cnt, beats_o, timeout);
        end
        for (int k = 0; k < obs_idx.size() && k < 32; k++) begin
            logic [4:0] exp_i;
            exp_i = 5'((k + 2) % 32);
            n_cmp++;
            if (obs_idx[k] !== exp_i || obs_first[k] !== 32'h100 * ({27'd0, exp_i} + 32'd1)) begin
                n_err++;
                $display("FAIL wrap_beat%0d got idx=%0d first=%h want idx=%0d", k, obs_idx[k], obs_first[k], exp_i);
            end
        end
    endtask

    task automatic test_backpressure();
        run_dump(5'd8, 6'd4, 1, 5, -1, 1'b0);
        n_cmp++;
        if (stable_err != 0) begin
            n_err++; $display("FAIL bp_stable got %0d unstable cycles want 0", stable_err);
        end
        n_cmp++;
        if (obs_idx.size() != 4 || done_cnt != 1 || beats_o !== 6'd4) begin
            n_err++;
            $display("FAIL bp_totals got beats=%0d done=%0d beats_o=%0d want 4/1/4", obs_idx.size(), done_cnt, beats_o);
        end
        for (int k = 0; k < obs_idx.size() && k < 4; k++) begin
            n_cmp++;
            if (obs_idx[k] !== 5'(4 + k)) begin
                n_err++; $display("FAIL bp_idx%0d got %0d want %0d", k, obs_idx[k], 4 + k);
            end
        end
        n_cmp++;
        if (obs_cyc.size() >= 3 && obs_cyc[1] != 9) begin
            n_err++; $display("FAIL bp_stall_len got accept at %0d want 9", obs_cyc[1]);
        end
    endtask

    task automatic test_empty();
        run_dump(5'd9, 6'd0, -1, 0, -1, 1'b0);
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 1) begin
            n_err++; $display("FAIL empty_done got count=%0d at %0d want 1 at 1", done_cnt, done_cyc);
        end
        n_cmp++;
        if (valid_seen != 0 || beats_o !== 6'd0) begin
            n_err++; $display("FAIL empty_beats got valid_cycles=%0d beats_o=%0d want 0/0", valid_seen, beats_o);
        end
    endtask

    task automatic test_abort();
        run_dump(5'd20, 6'd4, -1, 0, 1, 1'b0);
        n_cmp++;
        if (obs_idx.size() != 1 || done_cnt != 0 || exit_valid !== 1'b0 || beats_o !== 6'd1) begin
            n_err++;
            $display("FAIL abort_state got beats=%0d done=%0d valid=%b beats_o=%0d want 1/0/0/1",
                     obs_idx.size(), done_cnt, exit_valid, beats_o);
        end
        // abort wins over a simultaneous start
        @(negedge clk_i);
        start_i = 1'b1; abort_i = 1'b1; head_i = 5'd1; num_i = 6'd1;
        @(negedge clk_i);
        start_i = 1'b0; abort_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0 || beats_o !== 6'd1) begin
            n_err++; $display("FAIL abort_priority got busy=%b beats_o=%0d want 0/1", busy_o, beats_o);
        end
        run_dump(5'd20, 6'd2, -1, 0, -1, 1'b0);
        n_cmp++;
        if (obs_idx.size() != 2 || done_cnt != 1 || obs_idx[0] !== 5'd18 || obs_idx[1] !== 5'd19) begin
            n_err++; $display("FAIL abort_restart got beats=%0d done=%0d want idx 18,19 and one done", obs_idx.size(), done_cnt);
        end
    endtask

    task automatic test_big();
        mem_big[1] = 1'b1; mem_big[2] = 1'b1;
        run_dump(5'd4, 6'd4, -1, 0, -1, 1'b0);
`ifdef OM_REPORT_SKIP_BIG_EN
        n_cmp++;
        if (obs_idx.size() != 2 || done_cnt != 1 || beats_o !== 6'd2 ||
            obs_idx[0] !== 5'd0 || obs_idx[1] !== 5'd3) begin
            n_err++; $display("FAIL big_skip got beats=%0d done=%0d beats_o=%0d want idx 0,3 / 1 / 2",
                              obs_idx.size(), done_cnt, beats_o);
        end
`else
        n_cmp++;
        if (obs_idx.size() != 4 || done_cnt != 1 || beats_o !== 6'd4) begin
            n_err++; $display("FAIL big_count got beats=%0d done=%0d beats_o=%0d want 4/1/4",
                              obs_idx.size(), done_cnt, beats_o);
        end
        for (int k = 0; k < obs_big.size() && k < 4; k++) begin
            n_cmp++;
            if (obs_big[k] !== (k == 1 || k == 2) || obs_idx[k] !== 5'(k)) begin
                n_err++; $display("FAIL big_flag%0d got big=%b idx=%0d want big=%b idx=%0d",
                                  k, obs_big[k], obs_idx[k], (k == 1 || k == 2), k);
            end
        end
`endif
        mem_big[1] = 1'b0; mem_big[2] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dn;
        @(negedge clk_i);
        head_i = 5'd3; num_i = 6'd3; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0; out_ready_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; out_ready_i = 1'b1;
        n_cmp++;
        if ({out_valid_o, done_o, busy_o} !== 3'b000 || beats_o !== 6'd0 || out_first_o !== 32'd0) begin
            n_err++; $display("FAIL rst_mid got valid=%b done=%b busy=%b beats=%0d first=%h want all 0",
                              out_valid_o, done_o, busy_o, beats_o, out_first_o);
        end
        dn = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (done_o || out_valid_o) dn++;
        end
        n_cmp++;
        if (dn != 0) begin
            n_err++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", dn);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem_first[i] = 32'h100 * (i + 1);
            mem_last[i]  = 32'h100 * (i + 1) + 32'hFF;
            mem_big[i]   = 1'b0;
        end
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_empty();
        test_abort();
        test_big();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
